// File: rtl/stbus_slot_io.sv
// ST-BUS single-timeslot I/O stage: locks to the F0 frame pulse, extracts one
// channel byte from dsti and inserts a parallel byte into the same channel on dsto.
module stbus_slot_io #(
  parameter int SAMPLE_PHASE = 1,
  parameter int MISS_LIMIT   = 2
) (
  input  logic       c4,
  input  logic       rst,
  input  logic       f0,
  input  logic       dsti,
  input  logic [4:0] ch_sel,
  input  logic [7:0] tx_byte,
  output logic       dsto,
  output logic       dsto_oe,
  output logic       tx_ack,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       locked,
  output logic       frame_err
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int   MISS_W     = $clog2(MISS_LIMIT + 1);
  localparam logic SAMPLE_BIT = SAMPLE_PHASE[0];

  // frame counter and alignment state
  logic [8:0]        r_cnt;
  logic [8:0]        w_cnt_nxt;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [MISS_W-1:0] r_miss;
  logic [MISS_W-1:0] w_miss_nxt;
  logic              r_frame_err;
  logic              w_ferr_nxt;
  logic [4:0]        r_ch_sel_l;

  logic w_f0_seen;
  logic w_at_end;
  logic w_on_time;
  logic w_off_time;
  logic w_locked;
  logic w_lock_nxt;

  // transmit path
  logic [4:0] w_ch_nxt;
  logic       w_in_slot_nxt;
  logic       w_slot_first_nxt;
  logic [7:0] r_tx_buf;
  logic [7:0] w_tx_data;
  logic       w_tx_bit;
  logic       r_dsto;
  logic       r_dsto_oe;
  logic       r_tx_ack;

  // receive path
  logic       w_rx_sample;
  logic       w_rx_first;
  logic       w_rx_last;
  logic [6:0] r_rx_sh;
  logic       r_rx_run;
  logic       r_rx_valid;
  logic [7:0] r_rx_byte;

  assign w_f0_seen  = ~f0;
  assign w_at_end   = (r_cnt == 9'd511);
  assign w_on_time  = w_f0_seen && w_at_end;
  assign w_off_time = w_f0_seen && !w_at_end;
  assign w_cnt_nxt  = w_f0_seen ? 9'd0 : r_cnt + 9'd1;
  assign w_locked   = (r_state == ST_LOCKED);
  assign w_lock_nxt = (w_state_nxt == ST_LOCKED);

  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_f0_seen) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_on_time) begin
          w_state_nxt = ST_LOCKED;
          w_miss_nxt  = '0;
        end else if (w_off_time) begin
          w_ferr_nxt = 1'b1;
        end else if (w_at_end) begin
          w_state_nxt = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        if (w_on_time) begin
          w_miss_nxt = '0;
        end else if (w_off_time) begin
          w_ferr_nxt  = 1'b1;
          w_state_nxt = ST_CHECK;
          w_miss_nxt  = '0;
        end else if (w_at_end) begin
          if (r_miss == MISS_W'(MISS_LIMIT - 1)) begin
            w_state_nxt = ST_HUNT;
            w_miss_nxt  = '0;
          end else begin
            w_miss_nxt = r_miss + MISS_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_miss_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge c4) begin
    if (rst) begin
      r_cnt       <= '0;
      r_state     <= ST_HUNT;
      r_miss      <= '0;
      r_frame_err <= 1'b0;
      r_ch_sel_l  <= '0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_state     <= w_state_nxt;
      r_miss      <= w_miss_nxt;
      r_frame_err <= w_ferr_nxt;
      if (w_at_end) r_ch_sel_l <= ch_sel;
    end
  end

  // TX outputs are registered from the next count, so the channel select must
  // also be the one in force next cycle (fresh ch_sel across the frame wrap).
  assign w_ch_nxt         = w_at_end ? ch_sel : r_ch_sel_l;
  assign w_in_slot_nxt    = (w_cnt_nxt[8:4] == w_ch_nxt);
  assign w_slot_first_nxt = w_in_slot_nxt && (w_cnt_nxt[3:0] == 4'd0);
  assign w_tx_data        = w_slot_first_nxt ? tx_byte : r_tx_buf;
  assign w_tx_bit         = w_tx_data[3'd7 - w_cnt_nxt[3:1]];

  always_ff @(posedge c4) begin
    if (w_slot_first_nxt) r_tx_buf <= tx_byte;
  end

  always_ff @(posedge c4) begin
    if (rst) begin
      r_dsto    <= 1'b1;
      r_dsto_oe <= 1'b0;
      r_tx_ack  <= 1'b0;
    end else begin
      r_dsto_oe <= w_lock_nxt && w_in_slot_nxt;
      r_tx_ack  <= w_lock_nxt && w_slot_first_nxt;
      r_dsto    <= (w_lock_nxt && w_in_slot_nxt) ? w_tx_bit : 1'b1;
    end
  end

  // r_rx_run marks a byte whose every bit was taken while locked
  assign w_rx_sample = w_locked && (r_cnt[8:4] == r_ch_sel_l) && (r_cnt[0] == SAMPLE_BIT);
  assign w_rx_first  = w_rx_sample && (r_cnt[3:1] == 3'd0);
  assign w_rx_last   = w_rx_sample && (r_cnt[3:1] == 3'd7);

  always_ff @(posedge c4) begin
    if (w_rx_sample) r_rx_sh <= {r_rx_sh[5:0], dsti};
  end

  always_ff @(posedge c4) begin
    if (rst) begin
      r_rx_run   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_byte  <= 8'h00;
    end else begin
      r_rx_valid <= w_rx_last && r_rx_run;
      if (w_rx_last && r_rx_run) r_rx_byte <= {r_rx_sh, dsti};
      if (!w_locked)       r_rx_run <= 1'b0;
      else if (w_rx_first) r_rx_run <= 1'b1;
      else if (w_rx_last)  r_rx_run <= 1'b0;
    end
  end

  assign dsto      = r_dsto;
  assign dsto_oe   = r_dsto_oe;
  assign tx_ack    = r_tx_ack;
  assign rx_byte   = r_rx_byte;
  assign rx_valid  = r_rx_valid;
  assign locked    = w_locked;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_stbus_slot_io.sv
// Directed bench for stbus_slot_io: lock, RX/TX slot traffic, frame wrap,
// missing and misaligned F0, and reset in the middle of a slot.
module tb_stbus_slot_io;

  logic       c4;
  logic       rst;
  logic       f0;
  logic       dsti;
  logic [4:0] ch_sel;
  logic [7:0] tx_byte;
  logic       dsto;
  logic       dsto_oe;
  logic       tx_ack;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       locked;
  logic       frame_err;

  int         total;
  int         bad;
  logic [8:0] pos;
  logic       f0_en;
  logic [4:0] rx_ch;
  logic [7:0] rx_val;
  int         ferr_cnt;
  int         rxv_cnt;
  logic [8:0] rxv_pos;
  logic [7:0] rxv_byte;

  stbus_slot_io #(.SAMPLE_PHASE(1), .MISS_LIMIT(2)) dut (
    .c4       (c4),
    .rst      (rst),
    .f0       (f0),
    .dsti     (dsti),
    .ch_sel   (ch_sel),
    .tx_byte  (tx_byte),
    .dsto     (dsto),
    .dsto_oe  (dsto_oe),
    .tx_ack   (tx_ack),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .locked   (locked),
    .frame_err(frame_err)
  );

  initial c4 = 1'b0;
  always #5 c4 = ~c4;

  // pos is the frame position the DUT is in after each edge
  task automatic step();
    @(posedge c4);
    if (rst || !f0) pos = 9'd0;
    else            pos = pos + 9'd1;
    #1;
    if (frame_err) ferr_cnt++;
    if (rx_valid) begin
      rxv_cnt++;
      rxv_pos  = pos;
      rxv_byte = rx_byte;
    end
  endtask

  task automatic drive();
    f0 = !(f0_en && pos == 9'd511);
    if (pos[8:4] == rx_ch) dsti = rx_val[3'd7 - pos[3:1]];
    else                   dsti = 1'b1;
  endtask

  task automatic cycle();
    drive();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; f0 = 1'b1; dsti = 1'b1; ch_sel = 5'd3; tx_byte = 8'h00;
    f0_en = 1'b0; rx_ch = 5'd3; rx_val = 8'hFF; pos = 9'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({locked, dsto, dsto_oe, tx_ack, rx_valid, frame_err, rx_byte} !==
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
        bad++;
        $display("FAIL reset_values cyc=%0d: got l/d/oe/ack/v/err/byte=%b%b%b%b%b%b/%h want 010000/00",
                 i, locked, dsto, dsto_oe, tx_ack, rx_valid, frame_err, rx_byte);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    f0_en = 1'b1; ferr_cnt = 0;
    repeat (511) cycle();
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_hunt: got %b want 0", locked); end
    cycle();
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_after_f0_1: got %b want 0", locked); end
    repeat (511) cycle();
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_check: got %b want 0", locked); end
    cycle();
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_after_f0_2: got %b want 1", locked); end
    total++;
    if (ferr_cnt !== 0) begin bad++; $display("FAIL lock_no_frame_err: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_rx();
    logic [7:0] pats [2];
    pats[0] = 8'hA5; pats[1] = 8'h81;
    rx_ch = 5'd3;
    for (int k = 0; k < 2; k++) begin
      rx_val = pats[k]; rxv_cnt = 0;
      repeat (512) cycle();
      total++;
      if (rxv_cnt !== 1) begin bad++; $display("FAIL rx_count pat=%h: got %0d want 1", pats[k], rxv_cnt); end
      total++;
      if (rxv_pos !== 9'h040) begin bad++; $display("FAIL rx_pos pat=%h: got %h want 040", pats[k], rxv_pos); end
      total++;
      if (rxv_byte !== pats[k]) begin bad++; $display("FAIL rx_byte: got %h want %h", rxv_byte, pats[k]); end
    end
    rx_val = 8'hFF;
  endtask

  task automatic test_tx();
    logic [15:0] tx_exp;
    logic        exp_oe, exp_d, exp_ack;
    tx_exp = 16'b0000111111110000;
    ch_sel = 5'd0; tx_byte = 8'h3C;
    repeat (512) cycle();
    rxv_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      exp_oe  = (pos < 9'd16);
      exp_d   = exp_oe ? tx_exp[15 - int'(pos[3:0])] : 1'b1;
      exp_ack = (pos == 9'd0);
      total++;
      if ({dsto_oe, dsto, tx_ack} !== {exp_oe, exp_d, exp_ack}) begin
        bad++;
        $display("FAIL tx_slot pos=%0d: got oe/d/ack=%b%b%b want %b%b%b",
                 pos, dsto_oe, dsto, tx_ack, exp_oe, exp_d, exp_ack);
      end
      cycle();
    end
    total++;
    if (rxv_cnt !== 1 || rxv_pos !== 9'd16 || rxv_byte !== 8'hFF) begin
      bad++;
      $display("FAIL rx_slot0: got cnt=%0d pos=%0d byte=%h want 1 16 ff", rxv_cnt, rxv_pos, rxv_byte);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp32;
    logic        exp_d, exp_ack;
    exp32 = 32'b1111_0000_0000_1111_0011_0011_1100_1100;
    ch_sel = 5'd31; tx_byte = 8'hC3;
    repeat (512) cycle();
    repeat (496) cycle();
    for (int i = 0; i < 32; i++) begin
      exp_d   = exp32[31 - i];
      exp_ack = (i == 0 || i == 16);
      total++;
      if ({dsto_oe, dsto, tx_ack} !== {1'b1, exp_d, exp_ack}) begin
        bad++;
        $display("FAIL wrap_slot i=%0d: got oe/d/ack=%b%b%b want 1%b%b", i, dsto_oe, dsto, tx_ack, exp_d, exp_ack);
      end
      if (i == 0) begin
        tx_byte = 8'h5A; ch_sel = 5'd0;
      end
      cycle();
    end
    total++;
    if ({dsto_oe, dsto} !== 2'b01) begin bad++; $display("FAIL wrap_after: got oe/d=%b%b want 01", dsto_oe, dsto); end
  endtask

  task automatic test_missing();
    f0_en = 1'b0;
    repeat (496) cycle();
    total++;
    if ({locked, dsto_oe, tx_ack} !== 3'b111) begin
      bad++; $display("FAIL miss_one: got l/oe/ack=%b%b%b want 111", locked, dsto_oe, tx_ack);
    end
    f0_en = 1'b1;
    repeat (512) cycle();
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL miss_cleared: got %b want 1", locked); end
    f0_en = 1'b0;
    repeat (512) cycle();
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL miss_first_of_two: got %b want 1", locked); end
    repeat (512) cycle();
    total++;
    if ({locked, dsto_oe} !== 2'b00) begin bad++; $display("FAIL miss_two_hunt: got l/oe=%b%b want 00", locked, dsto_oe); end
    for (int i = 0; i < 16; i++) begin
      cycle();
      total++;
      if (dsto_oe !== 1'b0) begin bad++; $display("FAIL miss_oe_off pos=%0d: got %b want 0", pos, dsto_oe); end
    end
    f0_en = 1'b1;
    repeat (496) cycle();
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL relock_check: got %b want 0", locked); end
    repeat (512) cycle();
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL relock: got %b want 1", locked); end
  endtask

  task automatic test_misaligned();
    repeat (200) cycle();
    drive();
    f0 = 1'b0;
    step();
    total++;
    if ({frame_err, locked} !== 2'b10) begin
      bad++; $display("FAIL misalign_err: got err/l=%b%b want 10", frame_err, locked);
    end
    cycle();
    total++;
    if (frame_err !== 1'b0) begin bad++; $display("FAIL misalign_pulse_width: got %b want 0", frame_err); end
    repeat (510) cycle();
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL misalign_unlocked: got %b want 0", locked); end
    cycle();
    total++;
    if ({locked, tx_ack, dsto_oe} !== 3'b111) begin
      bad++; $display("FAIL misalign_relock: got l/ack/oe=%b%b%b want 111", locked, tx_ack, dsto_oe);
    end
  endtask

  task automatic test_reset_mid();
    ch_sel = 5'd3; rx_ch = 5'd3; rx_val = 8'hA5;
    repeat (512) cycle();
    repeat (52) cycle();
    drive();
    rst = 1'b1;
    step();
    total++;
    if ({locked, dsto, dsto_oe, tx_ack, rx_valid, frame_err, rx_byte} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL reset_mid: got l/d/oe/ack/v/err/byte=%b%b%b%b%b%b/%h want 010000/00",
               locked, dsto, dsto_oe, tx_ack, rx_valid, frame_err, rx_byte);
    end
    rst = 1'b0;
    rxv_cnt = 0;
    repeat (600) cycle();
    total++;
    if (rxv_cnt !== 0) begin bad++; $display("FAIL reset_mid_no_rx: got %0d want 0", rxv_cnt); end
  endtask

  initial begin
    total = 0; bad = 0; ferr_cnt = 0; rxv_cnt = 0;
    rxv_pos = '0; rxv_byte = '0;
    test_reset();
    test_lock();
    test_rx();
    test_tx();
    test_back_to_back();
    test_missing();
    test_misaligned();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stbus_slot_io.md
Name: stbus_slot_io

Overview:
- Downstream ST-BUS timeslot stage driven by the converter's 4.096 MHz C4 clock and active-low F0 frame pulse.
- Frame structure: 512 C4 cycles per 125 µs frame, giving 32 channels × 8 bits at 2.048 Mb/s, with each bit spanning 2 C4 cycles.
- The block locks to F0 and extracts one selected timeslot byte from the serial input.
- It inserts a parallel byte into the same timeslot on the serial output, driven with an output enable.

Parameters:
- SAMPLE_PHASE, 1: C4 half-bit phase (cnt[0] value) on which dsti is sampled.
- MISS_LIMIT, 2: consecutive missing F0 pulses tolerated in LOCKED before returning to HUNT.

Ports:
- c4 in 1: 4.096 MHz clock; all logic on the rising edge.
- rst in 1: reset.
- f0 in 1: frame pulse, active low, one C4 cycle wide, synchronous to c4.
- dsti in 1: ST-BUS serial data in, MSB first.
- ch_sel in 5: timeslot to extract and insert.
- tx_byte in 8: byte to insert into the selected slot.
- dsto out 1: serial data out.
- dsto_oe out 1: output enable for dsto (external tristate).
- tx_ack out 1: pulse, tx_byte consumed.
- rx_byte out 8: last extracted byte.
- rx_valid out 1: pulse, rx_byte updated.
- locked out 1: frame alignment established.
- frame_err out 1: pulse, F0 arrived at an unexpected position.

Behaviour:
- Clocking and reset (already decided): one clock, c4; rst is synchronous and active-high.
- Reset values: cnt=0, state=HUNT, rx_byte=8'h00, rx_valid=0, dsto=1, dsto_oe=0, tx_ack=0, locked=0, frame_err=0, miss counter=0.
  - Reset asserted mid-slot takes effect on the next edge and aborts any partial byte.
- cnt is a 9-bit free-running counter, 0..511, with natural wrap.
  - A cycle with f0==0 sampled forces cnt=0 on the next edge.
  - An "on-time" F0 is one sampled while cnt==511.
- Slot mapping: cnt[8:4] = channel, cnt[3:1] = bit index (0 = MSB), cnt[0] = half-bit phase.
- ch_sel_l (latched channel select) is loaded from ch_sel in the cycle where cnt==511. A mid-frame change of ch_sel therefore applies from the next frame.
- Alignment FSM:
  - HUNT: locked=0. Any F0 goes to CHECK; no frame_err.
  - CHECK:
    - On-time F0 goes to LOCKED (locked=1 from the next cycle).
    - Off-time F0 pulses frame_err, resyncs cnt, and stays in CHECK.
    - cnt==511 with f0==1 goes to HUNT.
  - LOCKED:
    - On-time F0 clears the miss counter.
    - Off-time F0 pulses frame_err, resyncs cnt, and goes to CHECK (locked=0).
    - cnt==511 with f0==1 increments the miss counter; reaching MISS_LIMIT goes to HUNT. cnt keeps free-running throughout.
- frame_err is registered: it is high for the one cycle after the offending F0 sample.
- RX path (active only while locked=1):
  - dsti is shifted in on cycles where cnt[8:4]==ch_sel_l and cnt[0]==SAMPLE_PHASE.
  - After the bit-7 sample, the next cycle has rx_byte = the assembled byte and rx_valid=1 for exactly one cycle.
  - If lock is lost mid-slot, the partial byte is discarded and there is no rx_valid.
- TX path (active only while locked=1):
  - The block latches tx_byte at cnt == ({ch_sel_l,4'h0}-1) mod 512.
  - tx_ack=1 for exactly the first cycle of the slot.
  - dsto_oe=1 exactly for the 16 cycles where cnt[8:4]==ch_sel_l.
  - During those cycles, dsto = latched byte bit (7 - cnt[3:1]).
  - Outside the slot, or when unlocked: dsto=1, dsto_oe=0, no tx_ack.
  - dsto and dsto_oe are registered, but aligned to the cnt values stated above (computed from the next count).
- Simultaneous events:
  - An F0 resync in the same cycle as a slot boundary: resync wins, and slot logic follows the new cnt.
  - ch_sel_l=31 with slot 0: the pre-load cycle wraps to cnt=511 and uses the freshly latched ch_sel_l.

Test Plan:
- Lock acquisition: rst for 4 cycles, then f0 low for 1 cycle every 512 cycles → locked=1 one cycle after the 2nd F0; frame_err never asserted.
- RX slot: locked, ch_sel=3, dsti carries 8'hA5 in cnt 48..63 with other slots 8'hFF → one rx_valid pulse per frame at cnt==0x40 with rx_byte=8'hA5.
- TX slot: locked, ch_sel=0, tx_byte=8'h3C → tx_ack at cnt 0; dsto_oe=1 for cnt 0..15; dsto = 0,0,1,1,1,1,0,0, each bit held 2 cycles; dsto=1 and dsto_oe=0 elsewhere.
- Misaligned F0: locked, inject f0 low at cnt==200 → frame_err pulse, locked=0, next cycle cnt=0; the following on-time F0 relocks.
- Missing F0: suppress 1 F0 → locked stays 1; suppress 2 consecutive F0 → state HUNT, locked=0, dsto_oe stays 0.
- Reset mid-slot: rst asserted at cnt==52 while locked with ch_sel=3 → next cycle all outputs at reset values; no rx_valid for that frame.
